biker_bullet_pool: RTL and testbench

- Downstream consumer of a biker's shootRequest and bikerTLX/bikerTLY outputs.
- Owns a small pool of projectiles: spawns each one at the biker's nose, moves it up the screen once per frame, and retires it at the top edge or on a hit.
- Emits a per-pixel drawingRequest/RGBout pair for the video mux and collision matrix.

---
 rtl/biker_bullet_pool.sv | 186 ++++++++++++++++++
 tb/tb_biker_bullet_pool.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biker_bullet_pool.sv
// biker_bullet_pool: fixed pool of bullets spawned at the biker's nose, moved up once per frame.
// Optional BIKER_BULLET_DOUBLE_EN: every shot spawns a side-by-side pair into the two lowest free slots.
module biker_bullet_pool #(
    parameter int         NUM_BULLETS     = 4,
    parameter int         BULLET_SPEED    = 8,
    parameter int         BULLET_W        = 4,
    parameter int         BULLET_H        = 8,
    parameter int         COOLDOWN_FRAMES = 6,
    parameter int         SPAWN_OFFSET_X  = 14,
    parameter logic [7:0] BULLET_COLOR    = 8'hE0
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   shootRequest,
    input  logic [10:0]            bikerTLX,
    input  logic [10:0]            bikerTLY,
    input  logic                   collision,
    input  logic                   endLevel,
    input  logic [10:0]            pixelX,
    input  logic [10:0]            pixelY,
    output logic                   drawingRequest,
    output logic [7:0]             RGBout,
    output logic [NUM_BULLETS-1:0] bulletsActive,
    output logic                   shotFired
);

    localparam int          IDX_W   = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
    localparam logic [10:0] SPEED   = 11'(BULLET_SPEED);
    localparam logic [10:0] HEIGHT  = 11'(BULLET_H);
    localparam logic [11:0] W12     = 12'(BULLET_W);
    localparam logic [11:0] H12     = 12'(BULLET_H);
    localparam logic [10:0] OFFS    = 11'(SPAWN_OFFSET_X);
    localparam logic [7:0]  CD_LOAD = 8'(COOLDOWN_FRAMES);

    logic [NUM_BULLETS-1:0] r_active;
    logic [10:0]            r_x [NUM_BULLETS];
    logic [10:0]            r_y [NUM_BULLETS];
    logic                   r_pending;
    logic [7:0]             r_cooldown;
    logic                   r_draw;
    logic [IDX_W-1:0]       r_hit_idx;
    logic                   r_shot_fired;

    logic [NUM_BULLETS-1:0] w_inside;
    logic                   w_draw;
    logic [IDX_W-1:0]       w_hit_idx;
    logic                   w_free0_ok;
    logic [IDX_W-1:0]       w_free0_idx;
    logic                   w_slots_ok;
    logic [7:0]             w_cd_dec;
    logic                   w_spawn;
    logic                   w_hit_clear;
    logic [10:0]            w_spawn_y;
    logic [10:0]            w_base_x;
`ifdef BIKER_BULLET_DOUBLE_EN
    localparam logic [10:0] SIDE = 11'(2 * BULLET_W);
    logic                   w_free1_ok;
    logic [IDX_W-1:0]       w_free1_idx;
`endif

    // Scan hit test; iterating downward leaves the lowest-index hit in w_hit_idx.
    always_comb begin
        w_inside  = '0;
        w_draw    = 1'b0;
        w_hit_idx = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            w_inside[i] = r_active[i]
                       && ({1'b0, pixelX} >= {1'b0, r_x[i]})
                       && ({1'b0, pixelX} <  ({1'b0, r_x[i]} + W12))
                       && ({1'b0, pixelY} >= {1'b0, r_y[i]})
                       && ({1'b0, pixelY} <  ({1'b0, r_y[i]} + H12));
            if (w_inside[i]) begin
                w_draw    = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    // Free slots are judged on the flags at the start of the cycle, so a bullet
    // retired by this frame's move is not reused until the following frame.
    always_comb begin
        w_free0_ok  = 1'b0;
        w_free0_idx = '0;
`ifdef BIKER_BULLET_DOUBLE_EN
        w_free1_ok  = 1'b0;
        w_free1_idx = '0;
`endif
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (!r_active[i]) begin
                if (!w_free0_ok) begin
                    w_free0_ok  = 1'b1;
                    w_free0_idx = IDX_W'(i);
                end
`ifdef BIKER_BULLET_DOUBLE_EN
                else if (!w_free1_ok) begin
                    w_free1_ok  = 1'b1;
                    w_free1_idx = IDX_W'(i);
                end
`endif
            end
        end
    end

`ifdef BIKER_BULLET_DOUBLE_EN
    assign w_slots_ok = w_free0_ok && w_free1_ok;
`else
    assign w_slots_ok = w_free0_ok;
`endif

    assign w_cd_dec    = (r_cooldown != 8'd0) ? (r_cooldown - 8'd1) : 8'd0;
    assign w_hit_clear = collision && r_draw;
    assign w_spawn     = startOfFrame && (r_pending || shootRequest) && (w_cd_dec == 8'd0)
                      && (bikerTLY >= HEIGHT) && w_slots_ok;
    assign w_spawn_y   = bikerTLY - HEIGHT;
    assign w_base_x    = bikerTLX + OFFS;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_active     <= '0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
            r_pending    <= 1'b0;
            r_cooldown   <= 8'd0;
            r_draw       <= 1'b0;
            r_hit_idx    <= '0;
            r_shot_fired <= 1'b0;
        end else begin
            r_shot_fired <= 1'b0;
            if (endLevel) begin
                r_active   <= '0;
                r_pending  <= 1'b0;
                r_cooldown <= 8'd0;
                r_draw     <= 1'b0;
                r_hit_idx  <= '0;
            end else begin
                r_draw    <= w_draw;
                r_hit_idx <= w_hit_idx;

                if (startOfFrame) begin
                    r_pending  <= 1'b0;
                    r_cooldown <= w_spawn ? CD_LOAD : w_cd_dec;
                end else if (shootRequest) begin
                    r_pending  <= 1'b1;
                end

                // A hit slot is retired in place and skips this frame's move.
                for (int i = 0; i < NUM_BULLETS; i++) begin
                    if (w_hit_clear && (r_hit_idx == IDX_W'(i))) begin
                        r_active[i] <= 1'b0;
                    end else if (startOfFrame && r_active[i]) begin
                        if (r_y[i] < SPEED) begin
                            r_active[i] <= 1'b0;
                        end else begin
                            r_y[i] <= r_y[i] - SPEED;
                        end
                    end
                end

                if (w_spawn) begin
                    r_shot_fired <= 1'b1;
`ifdef BIKER_BULLET_DOUBLE_EN
                    r_active[w_free0_idx] <= 1'b1;
                    r_x[w_free0_idx]      <= w_base_x - SIDE;
                    r_y[w_free0_idx]      <= w_spawn_y;
                    r_active[w_free1_idx] <= 1'b1;
                    r_x[w_free1_idx]      <= w_base_x + SIDE;
                    r_y[w_free1_idx]      <= w_spawn_y;
`else
                    r_active[w_free0_idx] <= 1'b1;
                    r_x[w_free0_idx]      <= w_base_x;
                    r_y[w_free0_idx]      <= w_spawn_y;
`endif
                end
            end
        end
    end

    assign drawingRequest = r_draw;
    assign RGBout         = r_draw ? BULLET_COLOR : 8'hFF;
    assign bulletsActive  = r_active;
    assign shotFired      = r_shot_fired;

endmodule

// File: tb/tb_biker_bullet_pool.sv
// Bench for biker_bullet_pool: vector table, corner-case sequences, and random traffic against a reference model.
module tb_biker_bullet_pool;

    localparam int NB       = 4;
    localparam int SPEED    = 8;
    localparam int BW       = 4;
    localparam int BH       = 8;
    localparam int COOLDOWN = 6;
    localparam int OFFS     = 14;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic        shootRequest;
    logic [10:0] bikerTLX;
    logic [10:0] bikerTLY;
    logic        collision;
    logic        endLevel;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        drawingRequest;
    logic [7:0]  RGBout;
    logic [NB-1:0] bulletsActive;
    logic        shotFired;

    int n_checks;
    int n_fail;

    biker_bullet_pool dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .shootRequest   (shootRequest),
        .bikerTLX       (bikerTLX),
        .bikerTLY       (bikerTLY),
        .collision      (collision),
        .endLevel       (endLevel),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .drawingRequest (drawingRequest),
        .RGBout         (RGBout),
        .bulletsActive  (bulletsActive),
        .shotFired      (shotFired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sof;
        logic       shoot;
        int         tlx;
        int         tly;
        int         px;
        int         py;
        logic       exp_draw;
        logic [3:0] exp_act;
        logic       exp_shot;
    } vec_t;

    vec_t vt[11];

    // Reference model: whole bullets as integer coordinates.
    bit m_act[NB];
    int m_x[NB];
    int m_y[NB];
    bit m_pending;
    int m_cd;
    bit m_draw;
    int m_hit;
    bit m_shot;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        startOfFrame = 1'b0;
        shootRequest = 1'b0;
        collision    = 1'b0;
        endLevel     = 1'b0;
        pixelX       = 11'd0;
        pixelY       = 11'd0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_act[i] = 1'b0;
            m_x[i]   = 0;
            m_y[i]   = 0;
        end
        m_pending = 1'b0;
        m_cd      = 0;
        m_draw    = 1'b0;
        m_hit     = 0;
        m_shot    = 1'b0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        bikerTLX = 11'd0;
        bikerTLY = 11'd0;
        resetN   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        tick();
        model_reset();
    endtask

    // One frame pulse; returns the shotFired value seen right after the frame edge.
    task automatic do_frame(output logic shot);
        startOfFrame = 1'b1;
        tick();
        shot = shotFired;
        startOfFrame = 1'b0;
        tick();
        tick();
    endtask

    task automatic model_step();
        bit nd;
        int nh;
        int hit_slot;
        bit act_old[NB];
        int free_q[$];
        nd = 1'b0;
        nh = 0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (m_act[i] && int'(pixelX) >= m_x[i] && int'(pixelX) < m_x[i] + BW
                && int'(pixelY) >= m_y[i] && int'(pixelY) < m_y[i] + BH) begin
                nd = 1'b1;
                nh = i;
            end
        end
        m_shot = 1'b0;
        if (endLevel) begin
            for (int i = 0; i < NB; i++) m_act[i] = 1'b0;
            m_pending = 1'b0;
            m_cd = 0;
            nd = 1'b0;
            nh = 0;
        end else begin
            act_old = m_act;
            hit_slot = -1;
            if (collision && m_draw) begin
                m_act[m_hit] = 1'b0;
                hit_slot = m_hit;
            end
            if (startOfFrame) begin
                for (int i = 0; i < NB; i++) begin
                    if (act_old[i] && i != hit_slot) begin
                        if (m_y[i] < SPEED) m_act[i] = 1'b0;
                        else m_y[i] = m_y[i] - SPEED;
                    end
                end
                if (m_cd > 0) m_cd--;
                for (int i = 0; i < NB; i++) if (!act_old[i]) free_q.push_back(i);
                if ((m_pending || shootRequest) && m_cd == 0 && int'(bikerTLY) >= BH
                    && free_q.size() >= 1) begin
                    m_act[free_q[0]] = 1'b1;
                    m_x[free_q[0]]   = (int'(bikerTLX) + OFFS) % 2048;
                    m_y[free_q[0]]   = int'(bikerTLY) - BH;
                    m_cd   = COOLDOWN;
                    m_shot = 1'b1;
                end
                m_pending = 1'b0;
            end else if (shootRequest) begin
                m_pending = 1'b1;
            end
        end
        m_draw = nd;
        m_hit  = nh;
    endtask

    function automatic logic [3:0] model_act();
        logic [3:0] v;
        for (int i = 0; i < NB; i++) v[i] = m_act[i];
        return v;
    endfunction

    initial begin
        logic sh;
        int   sof_cnt;
        int   k;
        int   pv;
        n_checks = 0;
        n_fail   = 0;
        resetN   = 1'b0;
        idle_inputs();
        bikerTLX = 11'd0;
        bikerTLY = 11'd0;

        vt[0]  = '{1'b0, 1'b1, 100, 400,   0,   0, 1'b0, 4'b0000, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 100, 400,   0,   0, 1'b0, 4'b0001, 1'b1};
        vt[2]  = '{1'b0, 1'b0, 100, 400,   0,   0, 1'b0, 4'b0001, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 100, 400,   0,   0, 1'b0, 4'b0001, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 100, 400, 115, 385, 1'b1, 4'b0001, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 100, 400, 118, 385, 1'b0, 4'b0001, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 100, 400, 114, 384, 1'b1, 4'b0001, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 100, 400, 117, 391, 1'b1, 4'b0001, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 100, 400, 113, 384, 1'b0, 4'b0001, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 100, 400, 114, 392, 1'b0, 4'b0001, 1'b0};
        vt[10] = '{1'b0, 1'b0, 100, 400, 114, 383, 1'b0, 4'b0001, 1'b0};

        // Reset values
        reset_dut();
        check("rst_act",  bulletsActive,  4'b0000);
        check("rst_draw", drawingRequest, 1'b0);
        check("rst_rgb",  RGBout,         8'hFF);
        check("rst_shot", shotFired,      1'b0);

        // Single shot, move and drawing window
        for (int i = 0; i < 11; i++) begin
            startOfFrame = vt[i].sof;
            shootRequest = vt[i].shoot;
            bikerTLX     = 11'(vt[i].tlx);
            bikerTLY     = 11'(vt[i].tly);
            pixelX       = 11'(vt[i].px);
            pixelY       = 11'(vt[i].py);
            tick();
            check($sformatf("vec%0d_draw", i), drawingRequest, vt[i].exp_draw);
            check($sformatf("vec%0d_rgb", i),  RGBout, vt[i].exp_draw ? 8'hE0 : 8'hFF);
            check($sformatf("vec%0d_act", i),  bulletsActive, vt[i].exp_act);
            check($sformatf("vec%0d_shot", i), shotFired, vt[i].exp_shot);
        end
        idle_inputs();

        // Cooldown: held request spawns on frames 0, 6, 12
        reset_dut();
        bikerTLX = 11'd100;
        bikerTLY = 11'd400;
        shootRequest = 1'b1;
        tick();
        for (int f = 0; f < 13; f++) begin
            do_frame(sh);
            check($sformatf("cd_shot_f%0d", f), sh, (f % 6) == 0);
        end
        check("cd_act", bulletsActive, 4'b0111);

        // Pool full: fifth attempt dropped
        reset_dut();
        bikerTLX = 11'd100;
        bikerTLY = 11'd400;
        shootRequest = 1'b1;
        tick();
        for (int f = 0; f < 26; f++) begin
            do_frame(sh);
            check($sformatf("full_shot_f%0d", f), sh, ((f % 6) == 0) && (f <= 18));
        end
        check("full_act", bulletsActive, 4'b1111);
        shootRequest = 1'b0;

        // Top exit: bullet spawned at Y=5 retires next frame
        reset_dut();
        bikerTLX = 11'd100;
        bikerTLY = 11'd13;
        shootRequest = 1'b1;
        tick();
        shootRequest = 1'b0;
        do_frame(sh);
        check("top_spawn_shot", sh, 1'b1);
        check("top_spawn_act", bulletsActive, 4'b0001);
        do_frame(sh);
        check("top_exit_act", bulletsActive, 4'b0000);

        // bikerTLY just below BULLET_H: dropped
        reset_dut();
        bikerTLX = 11'd100;
        bikerTLY = 11'd7;
        shootRequest = 1'b1;
        tick();
        shootRequest = 1'b0;
        do_frame(sh);
        check("low_y_shot", sh, 1'b0);
        check("low_y_act", bulletsActive, 4'b0000);

        // bikerTLY equal to BULLET_H: spawns at Y=0
        reset_dut();
        bikerTLX = 11'd100;
        bikerTLY = 11'd8;
        shootRequest = 1'b1;
        tick();
        shootRequest = 1'b0;
        do_frame(sh);
        check("edge_y_shot", sh, 1'b1);
        pixelX = 11'd114;
        pixelY = 11'd0;
        tick();
        check("edge_y_draw", drawingRequest, 1'b1);
        idle_inputs();

        // Collision: two bullets, hit slot1 only
        reset_dut();
        bikerTLX = 11'd100;
        bikerTLY = 11'd400;
        shootRequest = 1'b1;
        tick();
        for (int f = 0; f < 7; f++) begin
            if (f == 6) bikerTLX = 11'd300;
            do_frame(sh);
        end
        shootRequest = 1'b0;
        check("col_pre_act", bulletsActive, 4'b0011);
        pixelX = 11'd315;
        pixelY = 11'd393;
        tick();
        check("col_draw", drawingRequest, 1'b1);
        pixelX = 11'd0;
        pixelY = 11'd0;
        collision = 1'b1;
        tick();
        collision = 1'b0;
        check("col_hit_act", bulletsActive, 4'b0001);
        collision = 1'b1;
        tick();
        collision = 1'b0;
        check("col_nodraw_act", bulletsActive, 4'b0001);

        // endLevel while drawing slot0: drawing stops next cycle
        pixelX = 11'd115;
        pixelY = 11'd345;
        tick();
        check("el_pre_draw", drawingRequest, 1'b1);
        endLevel = 1'b1;
        tick();
        endLevel = 1'b0;
        check("el_draw", drawingRequest, 1'b0);
        check("el_act", bulletsActive, 4'b0000);
        idle_inputs();

        // endLevel with startOfFrame and a pending shot: no spawn, request cleared
        reset_dut();
        bikerTLX = 11'd100;
        bikerTLY = 11'd400;
        shootRequest = 1'b1;
        tick();
        shootRequest = 1'b0;
        endLevel = 1'b1;
        startOfFrame = 1'b1;
        tick();
        endLevel = 1'b0;
        startOfFrame = 1'b0;
        check("el_sof_act", bulletsActive, 4'b0000);
        tick();
        check("el_sof_shot", shotFired, 1'b0);
        do_frame(sh);
        check("el_pend_shot", sh, 1'b0);
        check("el_pend_act", bulletsActive, 4'b0000);

        // Asynchronous reset mid-flight
        reset_dut();
        bikerTLX = 11'd100;
        bikerTLY = 11'd400;
        shootRequest = 1'b1;
        tick();
        for (int f = 0; f < 6; f++) do_frame(sh);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        shootRequest = 1'b0;
        check("ar_pre_act", bulletsActive, 4'b0011);
        check("ar_pre_shot", shotFired, 1'b1);
        #1;
        resetN = 1'b0;
        #1;
        check("ar_act",  bulletsActive,  4'b0000);
        check("ar_shot", shotFired,      1'b0);
        check("ar_draw", drawingRequest, 1'b0);
        check("ar_rgb",  RGBout,         8'hFF);

        // Random traffic against the model
        reset_dut();
        sof_cnt = 3;
        for (int c = 0; c < 3000; c++) begin
            startOfFrame = (sof_cnt == 0);
            if (sof_cnt == 0) sof_cnt = $urandom_range(2, 9);
            else sof_cnt--;
            shootRequest = ($urandom_range(0, 99) < 30);
            collision    = ($urandom_range(0, 99) < 30);
            endLevel     = ($urandom_range(0, 199) == 0);
            bikerTLX     = 11'($urandom_range(0, 2047));
            if ($urandom_range(0, 4) == 0) bikerTLY = 11'($urandom_range(0, 20));
            else bikerTLY = 11'($urandom_range(300, 600));
            k = $urandom_range(0, NB - 1);
            if (m_act[k] && $urandom_range(0, 1) == 1) begin
                pv = m_x[k] + $urandom_range(0, 5) - 1;
                if (pv < 0) pv = 0;
                pixelX = 11'(pv % 2048);
                pv = m_y[k] + $urandom_range(0, 9) - 1;
                if (pv < 0) pv = 0;
                pixelY = 11'(pv % 2048);
            end else begin
                pixelX = 11'($urandom_range(0, 2047));
                pixelY = 11'($urandom_range(0, 2047));
            end
            model_step();
            tick();
            check("rnd_draw", drawingRequest, m_draw);
            check("rnd_rgb",  RGBout, m_draw ? 8'hE0 : 8'hFF);
            check("rnd_act",  bulletsActive, model_act());
            check("rnd_shot", shotFired, m_shot);
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
